// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and selectable FWFT/registered read.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_LEVEL  = 6,
  parameter int unsigned AEMPTY_LEVEL = 2,
  parameter int unsigned FWFT         = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  r_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  if (AFULL_LEVEL > DEPTH) begin : g_chk_afull
    $fatal(1, "fifo_sync_param: AFULL_LEVEL exceeds DEPTH");
  end
  if (AEMPTY_LEVEL >= DEPTH) begin : g_chk_aempty
    $fatal(1, "fifo_sync_param: AEMPTY_LEVEL must be below DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count, count_nx;
  logic                  rd_acc, wr_acc;

  always_comb begin
    rd_acc   = rd_i & ~empty_o;
    wr_acc   = wr_i & (~full_o | rd_acc);
    count_nx = count;
    if (wr_acc && !rd_acc) begin
      count_nx = count + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_nx = count - 1'b1;
    end
  end

  assign count_o = count;

  // Flags are registered from count_nx so they line up with count_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count          <= count_nx;
      empty_o        <= (count_nx == '0);
      full_o         <= (count_nx == DEPTH_C);
      almost_empty_o <= (count_nx <= AEMPTY_C);
      almost_full_o  <= (count_nx >= AFULL_C);
      overflow_o     <= overflow_o | (wr_i & ~wr_acc);
      underflow_o    <= underflow_o | (rd_i & ~rd_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !clr_i && wr_acc) begin
      mem[wr_ptr] <= w_data_i;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so reset reads as 0.
    always_comb begin
      r_data_o  = empty_o ? '0 : mem[rd_ptr];
      r_valid_o = ~empty_o;
    end
  end else begin : g_reg
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_data_o  <= '0;
        r_valid_o <= 1'b0;
      end else if (clr_i) begin
        r_valid_o <= 1'b0;
      end else begin
        r_valid_o <= rd_acc;
        if (rd_acc) r_data_o <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: FWFT instance u1 and registered-read instance u0.
module tb_fifo_sync_param;

  logic clk;
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic       rstn1, clr1, wr1, rd1;
  logic [7:0] wd1, rdat1;
  logic       rv1, full1, empty1, af1, ae1, ov1, un1;
  logic [3:0] cnt1;

  logic       rstn0, clr0, wr0, rd0;
  logic [7:0] wd0, rdat0;
  logic       rv0, full0, empty0, af0, ae0, ov0, un0;
  logic [3:0] cnt0;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .FWFT(1)) u1 (
    .clk_i(clk), .rst_ni(rstn1), .clr_i(clr1), .wr_i(wr1), .w_data_i(wd1), .rd_i(rd1),
    .r_data_o(rdat1), .r_valid_o(rv1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(cnt1),
    .overflow_o(ov1), .underflow_o(un1));

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(2), .FWFT(0)) u0 (
    .clk_i(clk), .rst_ni(rstn0), .clr_i(clr0), .wr_i(wr0), .w_data_i(wd0), .rd_i(rd0),
    .r_data_o(rdat0), .r_valid_o(rv0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(cnt0),
    .overflow_o(ov0), .underflow_o(un0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step1(input logic wr, input logic rd, input logic [7:0] d,
                       input logic clr, input logic rstn);
    wr1 = wr; rd1 = rd; wd1 = d; clr1 = clr; rstn1 = rstn;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; rstn1 = 1'b1;
  endtask

  task automatic step0(input logic wr, input logic rd, input logic [7:0] d,
                       input logic clr, input logic rstn);
    wr0 = wr; rd0 = rd; wd0 = d; clr0 = clr; rstn0 = rstn;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; rstn0 = 1'b1;
  endtask

  task automatic test_reset;
    step1(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    step0(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    total++; if (cnt1 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
    total++; if ({empty1, full1, ae1, af1} !== 4'b1010) begin bad++; $display("FAIL reset_flags got=%b exp=1010", {empty1, full1, ae1, af1}); end
    total++; if ({ov1, un1, rv1} !== 3'b000) begin bad++; $display("FAIL reset_sticky_valid got=%b exp=000", {ov1, un1, rv1}); end
    total++; if (rdat1 !== 8'h00) begin bad++; $display("FAIL reset_rdata_fwft got=%h exp=00", rdat1); end
    total++; if ({rdat0, rv0, empty0, cnt0} !== {8'h00, 1'b0, 1'b1, 4'd0}) begin bad++; $display("FAIL reset_reg_mode got=%h/%b/%b/%0d exp=00/0/1/0", rdat0, rv0, empty0, cnt0); end
  endtask

  task automatic test_single_write;
    step1(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
    total++; if ({cnt1, empty1, ae1, rv1} !== {4'd1, 1'b0, 1'b1, 1'b1}) begin bad++; $display("FAIL single_write_status got=%0d/%b/%b/%b exp=1/0/1/1", cnt1, empty1, ae1, rv1); end
    total++; if (rdat1 !== 8'h5A) begin bad++; $display("FAIL single_write_data got=%h exp=5a", rdat1); end
    step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({cnt1, empty1, rv1} !== {4'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL single_read_empty got=%0d/%b/%b exp=0/1/0", cnt1, empty1, rv1); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 8; i++) begin
      step1(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
      total++;
      if ({cnt1, af1, full1, ae1} !== {4'(i), 1'(i >= 6), 1'(i == 8), 1'(i <= 2)}) begin
        bad++; $display("FAIL fill_%0d got cnt=%0d af=%b full=%b ae=%b", i, cnt1, af1, full1, ae1);
      end
    end
    step1(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    total++; if ({ov1, cnt1, full1} !== {1'b1, 4'd8, 1'b1}) begin bad++; $display("FAIL overflow got ov=%b cnt=%0d full=%b exp=1/8/1", ov1, cnt1, full1); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (rdat1 !== 8'(i)) begin bad++; $display("FAIL drain_data_%0d got=%h exp=%h", i, rdat1, 8'(i)); end
      step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      total++; if (cnt1 !== 4'(8 - i)) begin bad++; $display("FAIL drain_count_%0d got=%0d exp=%0d", i, cnt1, 8 - i); end
    end
    total++; if ({empty1, un1} !== 2'b10) begin bad++; $display("FAIL drain_empty got empty=%b un=%b exp=1/0", empty1, un1); end
    step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({un1, ov1, cnt1} !== {1'b1, 1'b1, 4'd0}) begin bad++; $display("FAIL underflow got un=%b ov=%b cnt=%0d exp=1/1/0", un1, ov1, cnt1); end
  endtask

  task automatic test_back_to_back_full;
    step1(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    total++; if ({ov1, un1} !== 2'b00) begin bad++; $display("FAIL clr_sticky got=%b exp=00", {ov1, un1}); end
    // offset pointers so the steady-state traffic crosses the wrap point
    for (int i = 0; i < 3; i++) begin
      step1(1'b1, 1'b0, 8'hE0, 1'b0, 1'b1);
      step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    end
    for (int i = 1; i <= 8; i++) step1(1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, 1'b1, 8'(8'h11 + i), 1'b0, 1'b1);
      total++; if ({cnt1, full1, ov1} !== {4'd8, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_%0d got cnt=%0d full=%b ov=%b exp=8/1/0", i, cnt1, full1, ov1); end
    end
    for (int i = 0; i < 8; i++) begin
      total++; if (rdat1 !== 8'(8'h11 + i)) begin bad++; $display("FAIL wrap_data_%0d got=%h exp=%h", i, rdat1, 8'(8'h11 + i)); end
      step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    end
    total++; if ({empty1, un1} !== 2'b10) begin bad++; $display("FAIL wrap_end got empty=%b un=%b exp=1/0", empty1, un1); end
  endtask

  task automatic test_empty_rw;
    step1(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    total++; if ({cnt1, un1, empty1} !== {4'd1, 1'b1, 1'b0}) begin bad++; $display("FAIL empty_rw_status got cnt=%0d un=%b empty=%b exp=1/1/0", cnt1, un1, empty1); end
    total++; if (rdat1 !== 8'h33) begin bad++; $display("FAIL empty_rw_data got=%h exp=33", rdat1); end
  endtask

  task automatic test_registered_read;
    step0(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
    total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL reg_wr1_valid got=%b exp=0", rv0); end
    step0(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1);
    total++; if ({rv0, cnt0} !== {1'b0, 4'd2}) begin bad++; $display("FAIL reg_wr2 got rv=%b cnt=%0d exp=0/2", rv0, cnt0); end
    step0(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({rv0, rdat0} !== {1'b1, 8'hA1}) begin bad++; $display("FAIL reg_rd1 got rv=%b data=%h exp=1/a1", rv0, rdat0); end
    step0(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if ({rv0, rdat0} !== {1'b0, 8'hA1}) begin bad++; $display("FAIL reg_idle got rv=%b data=%h exp=0/a1", rv0, rdat0); end
    step0(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({rv0, rdat0} !== {1'b1, 8'hA2}) begin bad++; $display("FAIL reg_rd2 got rv=%b data=%h exp=1/a2", rv0, rdat0); end
    step0(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({rv0, rdat0, empty0, un0} !== {1'b0, 8'hA2, 1'b1, 1'b1}) begin bad++; $display("FAIL reg_rd_empty got rv=%b data=%h empty=%b un=%b exp=0/a2/1/1", rv0, rdat0, empty0, un0); end
    step0(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    total++; if ({rdat0, un0, rv0} !== {8'hA2, 1'b0, 1'b0}) begin bad++; $display("FAIL reg_clr_hold got data=%h un=%b rv=%b exp=a2/0/0", rdat0, un0, rv0); end
  endtask

  task automatic test_clear_reset;
    step1(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step1(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b1);
    step1(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step1(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    total++; if ({cnt1, ov1, rdat1} !== {4'd5, 1'b1, 8'h43}) begin bad++; $display("FAIL pre_clr got cnt=%0d ov=%b data=%h exp=5/1/43", cnt1, ov1, rdat1); end
    step1(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    total++; if ({cnt1, empty1, ov1, ae1, af1, full1} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL clr got cnt=%0d empty=%b ov=%b ae=%b af=%b full=%b", cnt1, empty1, ov1, ae1, af1, full1); end
    step1(1'b1, 1'b0, 8'h61, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 8'h62, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 8'h63, 1'b0, 1'b0);
    total++; if ({cnt1, empty1, full1, ae1, af1, ov1, un1, rv1, rdat1} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL mid_reset got cnt=%0d empty=%b full=%b ae=%b af=%b ov=%b un=%b rv=%b data=%h", cnt1, empty1, full1, ae1, af1, ov1, un1, rv1, rdat1);
    end
  endtask

  initial begin
    rstn1 = 1'b0; clr1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; wd1 = '0;
    rstn0 = 1'b0; clr0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; wd0 = '0;
    test_reset;
    test_single_write;
    test_fill_drain;
    test_back_to_back_full;
    test_empty_rw;
    test_registered_read;
    test_clear_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
